ro_measure_scheduler: RTL and testbench
=======================================

// Module: ro_measure_scheduler
// PURPOSE
// - Sequences one ring-oscillator PUF evaluation.
// - Accepts a challenge over valid/ready and applies it to the RO bank.
// - Selects each RO in turn, clears and gates the shared edge counter, and captures each count.
// - Compares adjacent counts and returns the response word over valid/ready.
// - Only owner of ro_sel/ro_en/cnt_clr; the RO bank and counter are external datapath.
// PARAMETERS
// NUM_RO   9      number of ring oscillators (>=2); response width NUM_RO-1
// CNT_W    16     width of external edge-counter value
// WINDOW   65535  gate length in count_clk cycles per RO (>=1)
// SETTLE   4      guard cycles before gate and before capture (>=0), covers CDC of cnt_value
// PORTS
// count_clk     in   1            measurement timebase clock
// reset         in   1            asynchronous, active-high
// req_valid     in   1            challenge request valid
// req_challenge in   8            challenge word
// req_ready     out  1            scheduler can accept a request
// abort         in   1            synchronous cancel of the evaluation in progress
// ro_challenge  out  8            challenge applied to RO bank, held during evaluation
// ro_sel        out  $clog2(NUM_RO) index of RO under measurement
// ro_en         out  1            enable selected RO (gate window)
// cnt_clr       out  1            one-cycle clear pulse to edge counter
// cnt_value     in   CNT_W        synchronised edge-counter value
// resp_valid    out  1            response available
// resp_data     out  NUM_RO-1     bit i = (count[i] > count[i+1])
// resp_ready    in   1            consumer takes response
// busy          out  1            high in every state except IDLE
// BEHAVIOUR
// - Reset values (async): state=IDLE, ro_en=0, cnt_clr=0, ro_sel=0, ro_challenge=0.
// - Reset values (async), continued: resp_valid=0, resp_data=0, busy=0, count regs=0.
// - Reset mid-evaluation discards everything and restarts from IDLE.
// - All outputs are registered except req_ready, which is (state==IDLE).
// - IDLE:
//   - On req_valid & req_ready: latch req_challenge into ro_challenge, set ro_sel=0, go CLEAR.
// - CLEAR (1 cycle): cnt_clr=1, ro_en=0; go SETTLE, or GATE if SETTLE==0.
// - SETTLE (SETTLE cycles): ro_en=0; then go GATE.
// - GATE (exactly WINDOW cycles): ro_en=1; then go CAPTURE.
// - CAPTURE (SETTLE+1 cycles): ro_en=0.
//   - On the final cycle, count[ro_sel] <= cnt_value.
//   - If ro_sel==NUM_RO-1, go COMPARE; else ro_sel++ and go CLEAR.
// - COMPARE (1 cycle):
//   - resp_data[i] <= count[i] > count[i+1], unsigned; a tie gives 0.
//   - Then go HOLD with resp_valid=1.
// - HOLD:
//   - resp_valid and resp_data stay stable until resp_ready is sampled high.
//   - Then resp_valid=0 next cycle and go IDLE.
//   - resp_data keeps its last value.
// - Latency:
//   - Accepting edge to resp_valid high = NUM_RO*(WINDOW+2*SETTLE+2)+1 cycles.
//   - Earliest next acceptance is 1 cycle after the resp handshake.
// - Requests arriving while busy are not accepted: req_ready=0, and the challenge is not latched.
// - abort:
//   - Active in any non-IDLE state except HOLD: next cycle ro_en=0, cnt_clr=0, state=IDLE.
//   - No response is produced and the count regs are left stale.
//   - In HOLD: ignored. In IDLE: ignored.
//   - abort together with req_valid in IDLE: request accepted.
// - ro_en and cnt_clr are never high in the same cycle.
// - ro_sel changes only while ro_en=0.
// - cnt_value is captured as-is; no saturation handling; counter overflow is the datapath's concern.
// TESTING
// Params NUM_RO=3, CNT_W=16, WINDOW=8, SETTLE=2 unless stated.
// 1. Basic run:
//    - Stimulus: req 0xA5; model returns counts 100,50,50.
//    - Required: ro_challenge=0xA5; resp_valid 43 cycles after accept; resp_data=2'b01.
//    - Required: 3 cnt_clr pulses; ro_en high 8 cycles per RO with ro_sel 0,1,2.
// 2. Backpressure:
//    - Stimulus: hold resp_ready=0 for 20 cycles.
//    - Required: resp_valid/resp_data stable; req_ready=0; a second req_valid is not accepted.
// 3. Abort:
//    - Stimulus: pulse abort during GATE of RO 1.
//    - Required: ro_en=0 next cycle; IDLE; no resp_valid; next req completes normally.
// 4. Async reset:
//    - Stimulus: assert reset mid-CAPTURE, off clock edge.
//    - Required: all outputs take reset values immediately; busy=0.
// 5. Back-to-back:
//    - Stimulus: req_valid held high with 0x01 then 0x02; resp_ready=1.
//    - Required: second accept 1 cycle after first resp handshake; two responses in order.
// 6. SETTLE=0, WINDOW=1:
//    - Required: CLEAR -> GATE directly; latency 3*(1+0+2)+1=10 cycles.
//    - Required: ro_en high exactly 1 cycle per RO.

Source files
------------

// File: rtl/ro_measure_scheduler_if.sv
// rtl/ro_measure_scheduler_if.sv - challenge request / response handshake bundle for the RO PUF scheduler
interface ro_measure_scheduler_if #(
  parameter int NUM_RO = 9
);
  logic              req_valid;
  logic [7:0]        req_challenge;
  logic              req_ready;
  logic              resp_valid;
  logic [NUM_RO-2:0] resp_data;
  logic              resp_ready;

  modport master (
    output req_valid, req_challenge, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_challenge, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/ro_measure_scheduler.sv
// rtl/ro_measure_scheduler.sv - sequences one ring-oscillator PUF evaluation over a shared edge counter
module ro_measure_scheduler #(
  parameter int NUM_RO = 9,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 65535,
  parameter int SETTLE = 4
) (
  input  logic                      count_clk,
  input  logic                      reset,
  ro_measure_scheduler_if.slave     bus,
  input  logic                      abort,
  output logic [7:0]                ro_challenge,
  output logic [$clog2(NUM_RO)-1:0] ro_sel,
  output logic                      ro_en,
  output logic                      cnt_clr,
  input  logic [CNT_W-1:0]          cnt_value,
  output logic                      busy
);
  localparam int SEL_W = $clog2(NUM_RO);
  localparam int TW    = $clog2(WINDOW + SETTLE + 2);
  localparam logic [TW-1:0]    GATE_LAST    = TW'(WINDOW - 1);
  localparam logic [TW-1:0]    SETTLE_LAST  = TW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [TW-1:0]    CAPTURE_LAST = TW'(SETTLE);
  localparam logic [SEL_W-1:0] SEL_LAST     = SEL_W'(NUM_RO - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_GATE, S_CAPTURE, S_COMPARE, S_HOLD
  } state_t;

  state_t            state, state_d;
  logic [TW-1:0]     timer, timer_d;
  logic [SEL_W-1:0]  sel_d;
  logic [7:0]        challenge_d;
  logic              capture;
  logic [CNT_W-1:0]  count [NUM_RO];
  logic [NUM_RO-2:0] cmp;

  assign bus.req_ready = (state == S_IDLE);

  always_comb begin
    cmp = '0;
    for (int i = 0; i < NUM_RO - 1; i++) begin
      cmp[i] = (count[i] > count[i+1]);
    end
  end

  // timer restarts at zero on every entry into SETTLE, GATE and CAPTURE
  always_comb begin
    state_d     = state;
    timer_d     = timer;
    sel_d       = ro_sel;
    challenge_d = ro_challenge;
    capture     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          challenge_d = bus.req_challenge;
          sel_d       = '0;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        timer_d = '0;
        state_d = (SETTLE == 0) ? S_GATE : S_SETTLE;
      end
      S_SETTLE: begin
        if (timer == SETTLE_LAST) begin
          timer_d = '0;
          state_d = S_GATE;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      S_GATE: begin
        if (timer == GATE_LAST) begin
          timer_d = '0;
          state_d = S_CAPTURE;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      S_CAPTURE: begin
        if (timer == CAPTURE_LAST) begin
          capture = 1'b1;
          if (ro_sel == SEL_LAST) begin
            state_d = S_COMPARE;
          end else begin
            sel_d   = ro_sel + SEL_W'(1);
            state_d = S_CLEAR;
          end
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      S_COMPARE: state_d = S_HOLD;
      S_HOLD: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state != S_IDLE && state != S_HOLD) begin
      state_d = S_IDLE;
      sel_d   = ro_sel;
      capture = 1'b0;
    end
  end

  always_ff @(posedge count_clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      timer          <= '0;
      ro_sel         <= '0;
      ro_challenge   <= '0;
      ro_en          <= 1'b0;
      cnt_clr        <= 1'b0;
      busy           <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      for (int i = 0; i < NUM_RO; i++) begin
        count[i] <= '0;
      end
    end else begin
      state          <= state_d;
      timer          <= timer_d;
      ro_sel         <= sel_d;
      ro_challenge   <= challenge_d;
      ro_en          <= (state_d == S_GATE);
      cnt_clr        <= (state_d == S_CLEAR);
      busy           <= (state_d != S_IDLE);
      bus.resp_valid <= (state_d == S_HOLD);
      if (capture) begin
        count[ro_sel] <= cnt_value;
      end
      if (state == S_COMPARE && state_d == S_HOLD) begin
        bus.resp_data <= cmp;
      end
    end
  end
endmodule

// File: tb/tb_ro_measure_scheduler.sv
// tb/tb_ro_measure_scheduler.sv - self-checking bench for ro_measure_scheduler
module tb_ro_measure_scheduler;
  logic count_clk = 1'b0;
  logic reset;
  always #5 count_clk = ~count_clk;

  ro_measure_scheduler_if #(.NUM_RO(3)) bus_a ();
  ro_measure_scheduler_if #(.NUM_RO(3)) bus_b ();

  logic        abort_a, abort_b;
  logic [7:0]  ch_a, ch_b;
  logic [1:0]  sel_a, sel_b;
  logic        en_a, en_b, clr_a, clr_b, busy_a, busy_b;
  logic [15:0] cnt_a, cnt_b;
  int          g_a = 0, g_b = 0;
  int          cyc = 0;
  int          checks = 0, errors = 0;

  ro_measure_scheduler #(.NUM_RO(3), .CNT_W(16), .WINDOW(8), .SETTLE(2)) dut_a (
    .count_clk(count_clk), .reset(reset), .bus(bus_a.slave), .abort(abort_a),
    .ro_challenge(ch_a), .ro_sel(sel_a), .ro_en(en_a), .cnt_clr(clr_a),
    .cnt_value(cnt_a), .busy(busy_a)
  );

  ro_measure_scheduler #(.NUM_RO(3), .CNT_W(16), .WINDOW(1), .SETTLE(0)) dut_b (
    .count_clk(count_clk), .reset(reset), .bus(bus_b.slave), .abort(abort_b),
    .ro_challenge(ch_b), .ro_sel(sel_b), .ro_en(en_b), .cnt_clr(clr_b),
    .cnt_value(cnt_b), .busy(busy_b)
  );

  // per-challenge RO counts; sel 0 in the low 16 bits
  function automatic logic [15:0] ro_count(input logic [7:0] ch, input logic [1:0] sel);
    logic [47:0] t;
    case (ch)
      8'hA5:   t = {16'd50, 16'd50, 16'd100};
      8'h01:   t = {16'd5, 16'd20, 16'd10};
      8'h02:   t = {16'd10, 16'd20, 16'd30};
      default: t = {8'h00, ch, 8'h00, ch + 8'd1, 8'h00, ch};
    endcase
    return (sel < 2'd3) ? t[sel*16 +: 16] : 16'hFFFF;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [7:0] ch);
    return {ro_count(ch, 2'd1) > ro_count(ch, 2'd2), ro_count(ch, 2'd0) > ro_count(ch, 2'd1)};
  endfunction

  // edge counter model: only a full gate window yields the oscillator's count
  always @(posedge count_clk) begin
    cyc <= cyc + 1;
    if (clr_a) g_a <= 0; else if (en_a) g_a <= g_a + 1;
    if (clr_b) g_b <= 0; else if (en_b) g_b <= g_b + 1;
  end
  assign cnt_a = (g_a == 8) ? ro_count(ch_a, sel_a) : 16'hFFFF;
  assign cnt_b = (g_b == 1) ? ro_count(ch_b, sel_b) : 16'hFFFF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int         acc_q[$];
  logic [1:0] exp_q[$];
  int         hs_edge = 0, acc_edge = 0, hs_n = 0, acc_n = 0, run = 0;
  logic       prev_valid = 1'b0;
  bit         skip = 1'b0;

  always @(negedge count_clk) begin
    #2;
    if (reset) begin
      run  = 0;
      skip = 1'b0;
    end else begin
      check("en_clr_excl", {31'd0, en_a & clr_a}, 32'd0);
      if (bus_a.req_valid && bus_a.req_ready) begin
        acc_q.push_back(cyc + 1);
        exp_q.push_back(exp_resp(bus_a.req_challenge));
        acc_edge = cyc + 1;
        acc_n++;
      end
      if (bus_a.resp_valid && !prev_valid) begin
        if (acc_q.size() == 0) check("lat_unexpected", acc_q.size(), 1);
        else check("latency", cyc - acc_q.pop_front(), 43);
      end
      if (bus_a.resp_valid && bus_a.resp_ready) begin
        if (exp_q.size() == 0) check("resp_unexpected", exp_q.size(), 1);
        else check("resp_data", bus_a.resp_data, exp_q.pop_front());
        hs_edge = cyc + 1;
        hs_n++;
      end
      if (abort_a) skip = 1'b1;
      if (en_a) run++;
      else if (run != 0) begin
        if (!skip) check("gate_len", run, 8);
        run  = 0;
        skip = 1'b0;
      end
    end
    prev_valid = bus_a.resp_valid;
  end

  task automatic step();
    @(negedge count_clk);
    #1;
  endtask

  task automatic wait_hs(input int n);
    int t = 0;
    while (hs_n < n && t < 300) begin
      step();
      t++;
    end
    check("hs_wait", hs_n, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n, clr_n, en_n, hb, ab;
    int en_per [4];
    logic [1:0] seen;
    bit seen_v, prev_clr, prev_en;

    reset = 1'b1;
    abort_a = 1'b0; abort_b = 1'b0;
    bus_a.req_valid = 1'b0; bus_a.req_challenge = 8'h00; bus_a.resp_ready = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.req_challenge = 8'h00; bus_b.resp_ready = 1'b0;
    step(); step();
    check("rst_outs", {en_a, clr_a, sel_a, ch_a, bus_a.resp_valid, bus_a.resp_data, busy_a}, 16'h0);
    check("rst_req_ready", bus_a.req_ready, 1);
    reset = 1'b0;
    step();

    // 1: basic run
    bus_a.resp_ready = 1'b1;
    bus_a.req_valid = 1'b1; bus_a.req_challenge = 8'hA5;
    step();
    bus_a.req_valid = 1'b0;
    check("t1_challenge", ch_a, 8'hA5);
    check("t1_busy", {busy_a, bus_a.req_ready}, 2'b10);
    clr_n = 0; en_per = '{default: 0}; seen = 2'bxx; t = 0;
    while (hs_n < 1 && t < 100) begin
      if (clr_a) clr_n++;
      if (en_a) en_per[sel_a]++;
      if (bus_a.resp_valid) seen = bus_a.resp_data;
      step();
      t++;
    end
    check("t1_clr_pulses", clr_n, 3);
    check("t1_en_ro0", en_per[0], 8);
    check("t1_en_ro1", en_per[1], 8);
    check("t1_en_ro2", en_per[2], 8);
    check("t1_en_ro3", en_per[3], 0);
    check("t1_resp", seen, 2'b01);

    // 2: backpressure; a second request must be ignored
    bus_a.resp_ready = 1'b0;
    bus_a.req_valid = 1'b1; bus_a.req_challenge = 8'h02;
    step();
    bus_a.req_valid = 1'b0;
    t = 0;
    while (!bus_a.resp_valid && t < 100) begin step(); t++; end
    check("t2_valid", bus_a.resp_valid, 1);
    for (int i = 0; i < 20; i++) begin
      bus_a.req_valid = 1'b1; bus_a.req_challenge = 8'h5A;
      step();
      check("t2_hold", {bus_a.resp_valid, bus_a.resp_data, bus_a.req_ready, ch_a}, {1'b1, 2'b11, 1'b0, 8'h02});
    end
    bus_a.req_valid = 1'b0;
    bus_a.resp_ready = 1'b1;
    wait_hs(2);
    check("t2_release", {bus_a.req_ready, bus_a.resp_valid, bus_a.resp_data, ch_a}, {1'b1, 1'b0, 2'b11, 8'h02});

    // 3: abort during gate of RO 1
    bus_a.req_valid = 1'b1; bus_a.req_challenge = 8'h01;
    step();
    bus_a.req_valid = 1'b0;
    t = 0;
    while (!(en_a && sel_a == 2'd1) && t < 200) begin step(); t++; end
    check("t3_gate_ro1", {en_a, sel_a}, 3'b101);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    check("t3_after_abort", {en_a, clr_a, busy_a, bus_a.req_ready}, 4'b0001);
    void'(acc_q.pop_back());
    void'(exp_q.pop_back());
    seen_v = 1'b0;
    repeat (50) begin
      step();
      if (bus_a.resp_valid) seen_v = 1'b1;
    end
    check("t3_no_resp", seen_v, 0);
    bus_a.req_valid = 1'b1; bus_a.req_challenge = 8'h01;
    step();
    bus_a.req_valid = 1'b0;
    wait_hs(3);

    // 4: asynchronous reset in the middle of CAPTURE
    bus_a.req_valid = 1'b1; bus_a.req_challenge = 8'h02;
    step();
    bus_a.req_valid = 1'b0;
    t = 0;
    while (!(en_a && sel_a == 2'd1) && t < 200) begin step(); t++; end
    while (en_a && t < 200) begin step(); t++; end
    check("t4_in_capture", {en_a, clr_a, busy_a, sel_a}, 5'b00101);
    #2 reset = 1'b1;
    #1;
    check("t4_rst_outs", {en_a, clr_a, sel_a, ch_a, bus_a.resp_valid, bus_a.resp_data, busy_a}, 16'h0);
    check("t4_rst_ready", bus_a.req_ready, 1);
    void'(acc_q.pop_back());
    void'(exp_q.pop_back());
    step();
    reset = 1'b0;
    step();

    // 5: back-to-back requests with req_valid held high
    hb = hs_n; ab = acc_n;
    bus_a.req_valid = 1'b1; bus_a.req_challenge = 8'h01;
    t = 0;
    while (acc_n == ab && t < 20) begin step(); t++; end
    bus_a.req_challenge = 8'h02;
    while (acc_n < ab + 2 && t < 300) begin step(); t++; end
    bus_a.req_valid = 1'b0;
    check("t5_accepts", acc_n, ab + 2);
    check("t5_b2b_gap", acc_edge - hs_edge, 1);
    wait_hs(hb + 2);
    check("t5_last_data", bus_a.resp_data, 2'b11);

    // 6: SETTLE=0, WINDOW=1
    bus_b.resp_ready = 1'b1;
    bus_b.req_valid = 1'b1; bus_b.req_challenge = 8'hA5;
    step();
    bus_b.req_valid = 1'b0;
    n = 0; en_n = 0; prev_clr = 1'b0; prev_en = 1'b0;
    while (!bus_b.resp_valid && n < 30) begin
      if (prev_clr) check("t6_clear_to_gate", en_b, 1);
      if (prev_en) check("t6_gate_1cyc", en_b, 0);
      prev_clr = clr_b;
      prev_en = en_b;
      if (en_b) en_n++;
      step();
      n++;
    end
    check("t6_latency", n, 10);
    check("t6_en_cycles", en_n, 3);
    check("t6_resp", bus_b.resp_data, 2'b01);
    step();
    check("t6_done", {bus_b.resp_valid, bus_b.req_ready, busy_b}, 3'b010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
